// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo block and its stream reader.
// Holds the data-width default, the read-buffer depth and the occupancy type.
package fifo_pkg;

  localparam int RBUF_DEPTH = 3;
  localparam int DWIDTH_DEF = 4;

  typedef logic [1:0] occ_t;

  // Circular index advance modulo RBUF_DEPTH.
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx == 2'(RBUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, depth 2**AWIDTH, registered read data one cycle after read_en.
// Latency: 1 cycle read. Backpressure: writes dropped when full or when read_en is high.
module fifo #(
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DWIDTH-1:0] data_in,
  output logic              full,
  input  logic              read_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              empty
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [AWIDTH:0]   count;
  logic              do_rd;
  logic              do_wr;

  assign empty = (count == '0);
  assign full  = (count == DEPTH[AWIDTH:0]);
  assign do_rd = read_en && !empty;
  // Reads win the single memory port; a write on a read cycle is not taken.
  assign do_wr = write_en && !full && !read_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (do_rd) begin
        data_out <= mem[rptr];
        rptr     <= rptr + 1'b1;
        count    <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= data_in;
  end

endmodule

// File: rtl/fifo_rd_buf.sv
// Three-entry circular holding buffer with push/pop and occupancy.
// Head word is presented combinationally from registered storage.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic              valid,
  output logic [DWIDTH-1:0] head_data
);

  logic [DWIDTH-1:0] mem [RBUF_DEPTH];
  logic [1:0]        head;
  logic [1:0]        tail;
  logic              pop_ok;

  assign valid     = (occ != 2'd0);
  assign head_data = mem[head];
  assign pop_ok    = pop && valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= 2'd0;
      tail <= 2'd0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= idx_inc(tail);
      end
      if (pop_ok) head <= idx_inc(head);
      occ <= occ + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && occ == 2'd3));
      assert (head != 2'd3 && tail != 2'd3);
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fifo read port onto a valid/ready stream at one word per cycle.
// Reads are credit-limited so occupancy plus the in-flight read never exceeds the buffer.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [CWIDTH-1:0] word_cnt
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] credit;

  assign credit     = {1'b0, occ} + {2'b00, inflight};
  // No dependence on m_ready: issue is decided purely from held plus in-flight words.
  assign fifo_rd_en = !rst && enable && !fifo_empty && (credit <= 3'd2);
  assign pop        = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end

  fifo_rd_buf #(.DWIDTH(DWIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .valid     (m_valid),
    .head_data (m_data)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: fifo (AWIDTH=4) feeding fifo_stream_reader, with a scoreboard on delivered words.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        wr_en;
  logic [3:0]  wr_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [3:0]  fifo_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  m_data;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int n_wr     = 0;
  int n_pop    = 0;
  logic [3:0] sbq[$];
  logic [3:0] sb_exp;
  logic [3:0] last_pop;
  logic       hold_pend = 1'b0;
  logic [3:0] hold_dat;

  fifo #(.DWIDTH(4), .AWIDTH(4)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .write_en (wr_en),
    .data_in  (wr_data),
    .full     (fifo_full),
    .read_en  (fifo_rd_en),
    .data_out (fifo_rdata),
    .empty    (fifo_empty)
  );

  fifo_stream_reader #(.DWIDTH(4), .CWIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .word_cnt   (word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accepted fifo writes, pop/compare on stream handshakes.
  always @(negedge clk) begin
    if (!rst && wr_en && !fifo_full && !fifo_rd_en) begin
      sbq.push_back(wr_data);
      n_wr++;
    end
    if (!rst && m_valid && m_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_extra_word: got %0h expected none", m_data);
      end else begin
        sb_exp = sbq.pop_front();
        chk("sb_order", 32'(m_data), 32'(sb_exp));
      end
      last_pop = m_data;
      n_pop++;
    end
    if (hold_pend && !rst) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(hold_dat));
    end
    hold_pend = m_valid && !m_ready && !rst;
    hold_dat  = m_data;
    chk("credit_le3", 32'({1'b0, dut.u_buf.occ} + {2'b00, dut.inflight} <= 3'd3), 32'd1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic reset_all();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; enable = 1'b0; m_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    sbq.delete();
  endtask

  // Holds a write until the fifo takes it; entered and left just after a rising edge.
  task automatic put(input logic [3:0] d);
    bit taken = 0;
    wr_en = 1'b1; wr_data = d;
    for (int t = 0; t < 50 && !taken; t++) begin
      @(negedge clk);
      taken = !fifo_full && !fifo_rd_en;
      @(posedge clk); #1;
    end
    if (!taken) chk("put_timeout", 32'd0, 32'd1);
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  wdat;
    logic        exp_empty;
    logic        exp_rd;
    logic        exp_vld;
    logic [3:0]  exp_dat;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vec [6];

  initial begin
    int rdc;
    int vc;
    int p0;
    int w0;
    bit found;

    vec[0] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 16'd0};
    vec[1] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 16'd0};
    vec[2] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd0};
    vec[3] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'hA, 16'd0};
    vec[4] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd1};
    vec[5] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 16'd1};

    // Reset state
    reset_all();
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    @(posedge clk); #1;

    // Single word, cycle by cycle
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = vec[i].wr; wr_data = vec[i].wdat;
      @(negedge clk);
      chk($sformatf("sw%0d_empty", i), 32'(fifo_empty), 32'(vec[i].exp_empty));
      chk($sformatf("sw%0d_rd_en", i), 32'(fifo_rd_en), 32'(vec[i].exp_rd));
      chk($sformatf("sw%0d_valid", i), 32'(m_valid), 32'(vec[i].exp_vld));
      if (vec[i].exp_vld) chk($sformatf("sw%0d_data", i), 32'(m_data), 32'(vec[i].exp_dat));
      chk($sformatf("sw%0d_cnt", i), 32'(word_cnt), 32'(vec[i].exp_cnt));
      @(posedge clk); #1;
    end
    wr_en = 1'b0;

    // Full-rate stream of 16 preloaded words
    reset_all();
    for (int i = 0; i < 16; i++) put(4'(i));
    chk("stream_full", 32'(fifo_full), 32'd1);
    enable = 1'b1; m_ready = 1'b1;
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      found = m_valid;
    end
    chk("stream_start", 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("stream_vld%0d", i), 32'(m_valid), 32'd1);
      chk($sformatf("stream_dat%0d", i), 32'(m_data), 32'(i));
    end
    @(negedge clk);
    chk("stream_end_vld", 32'(m_valid), 32'd0);
    chk("stream_cnt", 32'(word_cnt), 32'd16);
    chk("stream_empty", 32'(fifo_empty), 32'd1);
    @(posedge clk); #1;

    // Backpressure: only three reads while m_ready is low
    reset_all();
    for (int i = 0; i < 8; i++) put(4'(i + 8));
    enable = 1'b1; m_ready = 1'b0;
    rdc = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      rdc += int'(fifo_rd_en);
    end
    chk("bp_reads", 32'(rdc), 32'd3);
    chk("bp_occ", 32'(dut.u_buf.occ), 32'd3);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h8);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_data", 32'(m_data), 32'h8);
    @(negedge clk);
    chk("bp_rd_after_pop", 32'(fifo_rd_en), 32'd1);
    chk("bp_second_data", 32'(m_data), 32'h9);
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("bp_vld%0d", k), 32'(m_valid), 32'd1);
      chk($sformatf("bp_dat%0d", k), 32'(m_data), 32'(8 + k));
    end
    @(negedge clk);
    chk("bp_end_vld", 32'(m_valid), 32'd0);
    chk("bp_cnt", 32'(word_cnt), 32'd8);
    @(posedge clk); #1;

    // Enable dropped the cycle a read issues
    reset_all();
    for (int i = 0; i < 6; i++) put(4'(i + 2));
    enable = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("en_read_issued", 32'(fifo_rd_en), 32'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    p0 = n_pop;
    rdc = 0; vc = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      rdc += int'(fifo_rd_en);
      vc  += int'(m_valid);
    end
    @(posedge clk); #1;
    chk("en_off_reads", 32'(rdc), 32'd0);
    chk("en_off_valid_cycles", 32'(vc), 32'd1);
    chk("en_off_pops", 32'(n_pop - p0), 32'd1);
    enable = 1'b1;
    for (int t = 0; t < 30 && (n_pop - p0) < 6; t++) begin
      @(posedge clk); #1;
    end
    chk("en_resume_pops", 32'(n_pop - p0), 32'd6);
    chk("en_resume_sb_empty", 32'(sbq.size()), 32'd0);

    // Random m_ready with concurrent writes, 200 words
    reset_all();
    enable = 1'b1;
    p0 = n_pop; w0 = n_wr;
    for (int t = 0; t < 5000 && (n_pop - p0) < 200; t++) begin
      m_ready = 1'($urandom_range(0, 1));
      wr_en   = ((n_wr - w0) < 200) && ($urandom_range(0, 3) != 0);
      wr_data = 4'((n_wr - w0) * 5 + 3);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    chk("rand_pops", 32'(n_pop - p0), 32'd200);
    chk("rand_writes", 32'(n_wr - w0), 32'd200);
    chk("rand_sb_empty", 32'(sbq.size()), 32'd0);
    chk("rand_cnt", 32'(word_cnt), 32'd200);

    // Reset with occ=2 and a read in flight
    reset_all();
    for (int i = 0; i < 8; i++) put(4'(i + 1));
    enable = 1'b1; m_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #1;
      if (dut.u_buf.occ == 2'd2 && dut.inflight) found = 1;
      else m_ready = (k < 3);
    end
    chk("rm_reached_occ2_inflight", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("rm_valid", 32'(m_valid), 32'd0);
    chk("rm_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rm_cnt", 32'(word_cnt), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    p0 = n_pop;
    put(4'h5);
    put(4'h6);
    for (int t = 0; t < 20 && (n_pop - p0) < 2; t++) begin
      @(posedge clk); #1;
    end
    chk("rm_pops", 32'(n_pop - p0), 32'd2);
    chk("rm_last", 32'(last_pop), 32'h6);
    chk("rm_cnt_after", 32'(word_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
